// File: rtl/mem_port_arbiter_if.sv
// Request/ack and BlockRAM-side signals of the memory port arbiter.
// master is the requester/RAM side, slave is the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int D_WIDTH    = 32,
    parameter int MASK_WIDTH = 4
);
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_ack;
    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [D_WIDTH-1:0]    d_wdata;
    logic [MASK_WIDTH-1:0] d_mask;
    logic                  d_ack;
    logic [D_WIDTH-1:0]    rdata;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0]    mem_wdata;
    logic [MASK_WIDTH-1:0] mem_we_mask;
    logic [D_WIDTH-1:0]    mem_rdata;
    logic                  busy;
    logic                  grant_d;

    modport master (
        output f_req, f_addr,
        output d_req, d_addr, d_wdata, d_mask,
        output mem_rdata,
        input  f_ack, d_ack, rdata,
        input  mem_en, mem_addr, mem_wdata, mem_we_mask,
        input  busy, grant_d
    );

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_addr, d_wdata, d_mask,
        input  mem_rdata,
        output f_ack, d_ack, rdata,
        output mem_en, mem_addr, mem_wdata, mem_we_mask,
        output busy, grant_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin req/ack arbiter sharing one BlockRAM port between
// instruction fetch and the data load/store path (2-cycle latency).
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int D_WIDTH    = 32,
    parameter int MASK_WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state, state_n;

    logic                  en_q, en_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [D_WIDTH-1:0]    wdata_q, wdata_n;
    logic [MASK_WIDTH-1:0] mask_q, mask_n;
    logic                  f_ack_q, f_ack_n;
    logic                  d_ack_q, d_ack_n;
    logic                  busy_q, busy_n;
    logic                  grant_q, grant_n;
    logic                  take_f, take_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 1'b1;
        end else begin
            state   <= state_n;
            en_q    <= en_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            mask_q  <= mask_n;
            f_ack_q <= f_ack_n;
            d_ack_q <= d_ack_n;
            busy_q  <= busy_n;
            grant_q <= grant_n;
        end
    end

    always_comb begin
        state_n = state;
        en_n    = 1'b0;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        mask_n  = '0;
        f_ack_n = 1'b0;
        d_ack_n = 1'b0;
        busy_n  = 1'b0;
        grant_n = grant_q;
        take_f  = 1'b0;
        take_d  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.f_req && bus.d_req) begin
                    take_f = grant_q;
                    take_d = !grant_q;
                end else begin
                    take_f = bus.f_req;
                    take_d = bus.d_req;
                end
            end
            ISSUE: begin
                f_ack_n = !grant_q;
                d_ack_n = grant_q;
                busy_n  = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                // Only the other port may chain; the acked one must re-arm via IDLE.
                take_f  = grant_q && bus.f_req;
                take_d  = !grant_q && bus.d_req;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (take_f) begin
            addr_n  = bus.f_addr;
            mask_n  = '0;
            en_n    = 1'b1;
            grant_n = 1'b0;
            busy_n  = 1'b1;
            state_n = ISSUE;
        end else if (take_d) begin
            addr_n  = bus.d_addr;
            wdata_n = bus.d_wdata;
            mask_n  = bus.d_mask;
            en_n    = 1'b1;
            grant_n = 1'b1;
            busy_n  = 1'b1;
            state_n = ISSUE;
        end
    end

    assign bus.mem_en      = en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_we_mask = mask_q;
    assign bus.f_ack       = f_ack_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.busy        = busy_q;
    assign bus.grant_d     = grant_q;
    assign bus.rdata       = (f_ack_q || d_ack_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-masked BlockRAM model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_port_arbiter_if #(
        .ADDR_WIDTH(10),
        .D_WIDTH(32),
        .MASK_WIDTH(4)
    ) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(10),
        .D_WIDTH(32),
        .MASK_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:1023];
    logic [31:0] rd_q;
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we_mask[b])
                    ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            rd_q <= ram[bus.mem_addr];
        end
    end

    assign bus.mem_rdata = rd_q;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        nc();
        pre_we = 1'b0;
    endtask

    int cnt;

    initial begin
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_mask  = '0;
        rd_q        = '0;

        nc();
        preload(10'h004, 32'h0000_0013);
        preload(10'h010, 32'h1122_3344);
        preload(10'h020, 32'h5566_7788);

        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mask", bus.mem_we_mask, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_acks", {bus.f_ack, bus.d_ack}, 0);
        chk("rst_grant", bus.grant_d, 1);
        rst = 1'b1;
        nc();

        // single fetch
        bus.f_req  = 1'b1;
        bus.f_addr = 10'h004;
        nc();
        chk("f_iss_en", bus.mem_en, 1);
        chk("f_iss_addr", bus.mem_addr, 10'h004);
        chk("f_iss_mask", bus.mem_we_mask, 0);
        chk("f_iss_grant", bus.grant_d, 0);
        chk("f_iss_ack", {bus.f_ack, bus.d_ack}, 0);
        nc();
        chk("f_resp_ack", {bus.f_ack, bus.d_ack}, 2'b10);
        chk("f_resp_rdata", bus.rdata, 32'h0000_0013);
        chk("f_resp_en", bus.mem_en, 0);
        bus.f_req = 1'b0;
        nc();
        chk("f_idle_busy", bus.busy, 0);

        // masked write, then fetch chained from RESP
        bus.d_req   = 1'b1;
        bus.d_addr  = 10'h010;
        bus.d_mask  = 4'b0011;
        bus.d_wdata = 32'hAABB_CCDD;
        nc();
        chk("w_iss_mask", bus.mem_we_mask, 4'b0011);
        chk("w_iss_addr", bus.mem_addr, 10'h010);
        chk("w_iss_wdata", bus.mem_wdata, 32'hAABB_CCDD);
        chk("w_iss_grant", bus.grant_d, 1);
        nc();
        chk("w_resp_ack", {bus.f_ack, bus.d_ack}, 2'b01);
        chk("w_resp_mask", bus.mem_we_mask, 0);
        bus.d_req  = 1'b0;
        bus.f_req  = 1'b1;
        bus.f_addr = 10'h010;
        nc();
        chk("rb_iss_en", bus.mem_en, 1);
        chk("rb_iss_mask", bus.mem_we_mask, 0);
        chk("rb_iss_grant", bus.grant_d, 0);
        nc();
        chk("rb_ack", bus.f_ack, 1);
        chk("rb_rdata", bus.rdata, 32'h1122_CCDD);
        bus.f_req = 1'b0;
        nc();
        chk("rb_idle", bus.busy, 0);

        // simultaneous reqs right after reset
        rst = 1'b0;
        nc();
        chk("rst2_grant", bus.grant_d, 1);
        rst = 1'b1;
        bus.f_req  = 1'b1;
        bus.f_addr = 10'h004;
        bus.d_req  = 1'b1;
        bus.d_addr = 10'h010;
        bus.d_mask = 4'b0000;
        nc();
        chk("tie_iss_grant", bus.grant_d, 0);
        chk("tie_iss_addr", bus.mem_addr, 10'h004);
        nc();
        chk("tie_f_ack", {bus.f_ack, bus.d_ack}, 2'b10);
        chk("tie_f_rdata", bus.rdata, 32'h0000_0013);
        bus.f_req = 1'b0;
        nc();
        chk("tie_b2b_busy", bus.busy, 1);
        chk("tie_b2b_en", bus.mem_en, 1);
        chk("tie_b2b_grant", bus.grant_d, 1);
        chk("tie_b2b_addr", bus.mem_addr, 10'h010);
        chk("tie_b2b_ack", {bus.f_ack, bus.d_ack}, 0);
        nc();
        chk("tie_d_ack", {bus.f_ack, bus.d_ack}, 2'b01);
        chk("tie_d_rdata", bus.rdata, 32'h1122_CCDD);
        bus.d_req = 1'b0;
        nc();
        chk("tie_idle", bus.busy, 0);

        // sustained contention: f,d,f,d every 2 cycles
        bus.f_req = 1'b1;
        bus.d_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            nc();
            chk($sformatf("rr_f_ack_%0d", k), bus.f_ack, (k % 4) == 2);
            chk($sformatf("rr_d_ack_%0d", k), bus.d_ack, (k % 4) == 0);
        end
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        nc();
        chk("rr_idle", bus.busy, 0);

        // reset during ISSUE of a full write
        bus.d_req   = 1'b1;
        bus.d_addr  = 10'h020;
        bus.d_mask  = 4'b1111;
        bus.d_wdata = 32'hDEAD_BEEF;
        nc();
        chk("ar_iss_en", bus.mem_en, 1);
        chk("ar_iss_mask", bus.mem_we_mask, 4'b1111);
        #1 rst = 1'b0;
        bus.d_req = 1'b0;
        #1;
        chk("ar_en", bus.mem_en, 0);
        chk("ar_mask", bus.mem_we_mask, 0);
        chk("ar_busy", bus.busy, 0);
        nc();
        chk("ar_no_ack", {bus.f_ack, bus.d_ack}, 0);
        rst = 1'b1;
        bus.f_req  = 1'b1;
        bus.f_addr = 10'h020;
        nc();
        nc();
        chk("ar_rb_ack", bus.f_ack, 1);
        chk("ar_rb_rdata", bus.rdata, 32'h5566_7788);
        bus.f_req = 1'b0;
        nc();

        // held fetch req must not be serviced twice from RESP
        bus.f_req  = 1'b1;
        bus.f_addr = 10'h004;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            nc();
            if (bus.f_ack) cnt++;
            if (k == 3) begin
                chk("hold_idle_busy", bus.busy, 0);
                chk("hold_idle_en", bus.mem_en, 0);
                bus.f_req = 1'b0;
            end
        end
        chk("hold_ack_count", cnt, 1);

        // req dropped early and addr changed while granted
        bus.d_req  = 1'b1;
        bus.d_addr = 10'h010;
        bus.d_mask = 4'b0000;
        nc();
        chk("pv_iss_addr", bus.mem_addr, 10'h010);
        bus.d_req  = 1'b0;
        bus.d_addr = 10'h3FF;
        nc();
        chk("pv_ack", {bus.f_ack, bus.d_ack}, 2'b01);
        chk("pv_rdata", bus.rdata, 32'h1122_CCDD);
        chk("pv_addr_held", bus.mem_addr, 10'h010);
        nc();
        chk("pv_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port BlockRAM between two requesters: instruction fetch from the control unit's PC path, and the data serialiser's load/store path.
- Replaces the combinational pc_addr_en address mux with a sequenced req/ack transaction engine.
- Uses round-robin fairness and fixed 2-cycle access latency.
- Sits between Control_Unit/Data_Serialiser and BlockRAMwithMask.

Parameters:
- ADDR_WIDTH, 10, word address width into the BlockRAM.
- D_WIDTH, 32, data word width.
- MASK_WIDTH, 4, byte write-mask width (D_WIDTH/8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  ADDR_WIDTH  fetch word address (pc[11:2]); held stable with f_req.
- f_ack  out  1  one-cycle pulse; rdata valid for fetch this cycle.
- d_req  in  1  data request; held high until d_ack.
- d_addr  in  ADDR_WIDTH  data word address; held stable with d_req.
- d_wdata  in  D_WIDTH  store data; held stable with d_req.
- d_mask  in  MASK_WIDTH  byte write enables; 0 = read, nonzero = write.
- d_ack  out  1  one-cycle pulse; data transaction complete.
- rdata  out  D_WIDTH  read data, valid only while f_ack or d_ack is high.
- mem_en  out  1  BlockRAM enable.
- mem_addr  out  ADDR_WIDTH  BlockRAM address.
- mem_wdata  out  D_WIDTH  BlockRAM write data.
- mem_we_mask  out  MASK_WIDTH  BlockRAM byte write mask.
- mem_rdata  in  D_WIDTH  BlockRAM read data (registered, 1-cycle latency).
- busy  out  1  high in ISSUE and RESP.
- grant_d  out  1  current or last transaction owner: 1 = data, 0 = fetch.

Behaviour:
- State machine: IDLE, ISSUE, RESP. All outputs except rdata are registered.
- Reset (rst low, asynchronous, any state):
  - state = IDLE.
  - mem_en, mem_addr, mem_wdata, mem_we_mask, f_ack, d_ack, busy = 0.
  - grant_d = 1, so fetch wins the first tie.
  - An in-flight transaction is abandoned without an ack.
- IDLE:
  - No req: stay.
  - One req: latch that requester's addr/wdata/mask into the mem_* registers and set grant_d. Next state ISSUE.
  - Both req: grant the requester opposite to grant_d (round-robin).
- ISSUE (1 cycle):
  - mem_en = 1. mem_addr/mem_wdata/mem_we_mask hold the latched values.
  - For fetch grants, mem_we_mask is forced to 0.
  - Next state RESP.
- RESP (1 cycle):
  - mem_en = 0 and mem_we_mask = 0.
  - rdata = mem_rdata, passed through combinationally.
  - Pulse f_ack or d_ack according to grant_d.
  - On writes, rdata content is don't-care.
- RESP next-state:
  - Other requester's req high: latch it, toggle grant_d, go directly to ISSUE (back-to-back).
  - Otherwise go to IDLE.
  - The just-acked requester's req is ignored in the RESP cycle, so a still-high req is not double-serviced.
- Latency and throughput:
  - req sampled in IDLE → ack 2 cycles later.
  - Sustained alternating traffic runs at 1 access per 2 cycles.
  - A single requester streaming runs at 1 access per 3 cycles.
- Acks are mutually exclusive and never asserted outside RESP.
- A req is never acked more than once per assertion, provided the requester drops req in the cycle after its ack.
- Protocol violations:
  - req dropped before ack: the access still completes and the ack still pulses.
  - addr changed while granted: the latched value is used.
- Starvation bound: a continuously requesting port is acked within 5 cycles of req assertion.

Test Plan:
- Reset, then f_req=1, f_addr=0x004, mem preloaded 0x00000013 at word 4 → mem_en high exactly 1 cycle with mem_addr=0x004, mem_we_mask=0; f_ack 2 cycles after req with rdata=0x00000013.
- d_req, d_addr=0x010, d_mask=4'b0011, d_wdata=0xAABBCCDD → mem_we_mask=0011 during ISSUE. A following read of 0x010 returns low half 0xCCDD, upper bytes unchanged.
- f_req and d_req rise the same cycle after reset → fetch acked first, data acked 2 cycles later via the RESP→ISSUE path; no IDLE cycle between.
- Both reqs held high for 20 cycles → acks alternate f,d,f,d; neither port waits more than 5 cycles.
- rst driven low during ISSUE of a write → mem_en and mem_we_mask drop to 0 asynchronously in the same cycle; no ack; memory word unchanged when the first write edge is suppressed.
- f_req held high the cycle after f_ack, with no d_req → no second f_ack until the FSM passes through IDLE (ack count equals req assertion count).
